shift_out: RTL and testbench
============================

# shift_out

Parallel-in, serial-out transmitter that is the sending end of the serial bit link consumed by `shift_reg`. It accepts a `MSB`-bit word on a valid/ready handshake and drives it onto a single serial line MSB-first, one bit per enabled clock. Back-to-back words stream with no idle bit between them. It feeds FFT sample words from the parallel datapath into the serial test/loopback path.

## Interface
- `MSB`, 16: word width in bits; legal range 2..32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  bit-rate enable; the line advances one bit only on edges where `en`=1.
- `din`  in  `MSB`  parallel word; sampled only on the acceptance edge.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  block will accept `din` on this edge.
- `q`  out  1  serial data, MSB-first; drives the `d` input of `shift_reg`.
- `q_valid`  out  1  `q` carries a data bit.
- `q_last`  out  1  `q` carries bit 0 of the current word.

## Operation
- States: IDLE and SHIFT. Registers: shift register `sreg[MSB-1:0]` and bit counter `cnt` of width $clog2(MSB).
- IDLE: `din_ready`=1. When `din_valid`=1, go to SHIFT, set `sreg`<=`din`, and set `cnt`<=`MSB-1`. `en` is ignored for acceptance.
- SHIFT: `q`=`sreg[MSB-1]`, `q_valid`=1, `q_last`=(`cnt`==0).
- SHIFT with `en`=1 and `cnt`!=0: `sreg`<=`sreg`<<1 (zero fill) and `cnt`<=`cnt`-1.
- SHIFT with `en`=1 and `cnt`==0 (last bit consumed):
  - `din_valid`=1: reload `sreg`/`cnt` from `din` and stay in SHIFT. This is the back-to-back case with no gap bit.
  - `din_valid`=0: go to IDLE.
- SHIFT with `en`=0: all state holds and `q` is stable.
- `din_ready` = !`rst` && (IDLE || (SHIFT && `cnt`==0 && `en`)). It is combinational from state and `en`.
- `din_valid` during SHIFT when `din_ready`=0 is ignored. No word is captured and none is lost internally; the sender must hold the word.
- IDLE outputs: `q`=0, `q_valid`=0, `q_last`=0.
- Bit counter width is $clog2(MSB). `MSB` not a power of two needs no special case, because terminal detect is `cnt`==0.

## Timing
- Reset values: state=IDLE, `sreg`=0, `cnt`=0, `q`=0, `q_valid`=0, `q_last`=0, `din_ready`=0 while `rst` is high.
- Reset takes effect immediately, without a clock edge. Reset mid-word aborts the word: remaining bits are dropped and nothing resumes after release.
- After reset release, `din_ready`=1 in the first cycle.
- Latency: a word accepted at edge N has its bit `MSB-1` on `q` after edge N, i.e. 1 cycle.
- With `en` held at 1, a word occupies exactly `MSB` cycles, and `q_last` is high in the `MSB`-th cycle.
- With `en` duty-cycled, each bit stays on `q` until the next edge with `en`=1.
- Consumer contract: `shift_reg` samples `q` on the same edges where `en`=1. After `MSB` such edges, the consumer's register holds the word MSB-aligned.
- Simultaneous rst and `din_valid`: reset wins and no word is accepted.

## Structure
- Shared package `shift_pkg` holds the state typedef (IDLE, SHIFT) and the default width constant (16) used by both `shift_out` and `shift_reg` benches.
- No sub-module is needed. Counter, shift register and FSM are a single always block plus combinational output assigns, about 120-150 lines.

## Test plan
All scenarios use `MSB`=8.
- Single word, `en`=1: accept 8'hAB → `q` = 1,0,1,0,1,0,1,1 over 8 cycles starting one cycle after acceptance; `q_last` high only in cycle 8; then `q_valid`=0.
- Back-to-back, `en`=1: `din_valid` held with 8'hAB then 8'h3C presented at the last-bit edge → 16 contiguous bits 10101011 00111100; `q_valid` never drops; `q_last` high at bits 8 and 16.
- Duty-cycled enable: `en` toggles 1,0,1,0… while sending 8'hAB → each bit held 2 cycles; the word completes in 16 cycles; `din_ready` stays 0 until the final enabled edge.
- Reset mid-word: assert `rst` after 3 bits of 8'hFF → `q`/`q_valid`/`q_last` go to 0 immediately; after release, sending 8'h81 produces exactly 1,0,0,0,0,0,0,1.
- Busy ignore: present 8'h55 with `din_valid`=1 while 8'hAB is mid-word → 8'hAB completes unaltered; 8'h55 is accepted only at the last-bit edge and follows with no gap.
- Loopback: `q` drives `shift_reg` `d` with the same `clk`/`en`; send 8'hAB → after 8 enabled edges `shift_reg` holds 8'hAB.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the serial bit link (shift_out transmitter and
// shift_reg receiver): FSM state encoding and the default word width.
package shift_pkg;

    // Default word width in bits for both ends of the link.
    localparam int DEFAULT_MSB = 16;

    // Transmitter states: waiting for a word, or driving its bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : shift_pkg

// File: rtl/shift_out.sv
// Parallel-in, serial-out transmitter. Accepts a word on a valid/ready
// handshake and drives it MSB-first onto q, one bit per enabled clock.
// Back-to-back words follow each other with no idle bit in between.
module shift_out
    import shift_pkg::*;
#(
    parameter int MSB = DEFAULT_MSB
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [MSB-1:0] din,
    input  logic           din_valid,
    output logic           din_ready,
    output logic           q,
    output logic           q_valid,
    output logic           q_last
);

    localparam int CW = $clog2(MSB);

    // Counter value loaded with a fresh word: number of bits still to go
    // after the one currently on the line.
    localparam logic [CW-1:0] CNT_TOP  = CW'(MSB - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t         state_r;
    state_t         state_s;
    logic [MSB-1:0] sreg_r;
    logic [MSB-1:0] sreg_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic           cnt_zero_s;

    assign cnt_zero_s = (cnt_r == CNT_ZERO);

    // Next-state, shift and counter logic; all paths assign every target.
    always_comb begin
        state_s = state_r;
        sreg_s  = sreg_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                // Acceptance in IDLE does not wait for the bit-rate enable.
                if (din_valid) begin
                    state_s = SHIFT;
                    sreg_s  = din;
                    cnt_s   = CNT_TOP;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!cnt_zero_s) begin
                        sreg_s = {sreg_r[MSB-2:0], 1'b0};
                        cnt_s  = cnt_r - CNT_ONE;
                    end else if (din_valid) begin
                        // Last bit consumed and another word waiting:
                        // reload without a gap bit.
                        sreg_s = din;
                        cnt_s  = CNT_TOP;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    // Enable low: hold everything so q stays stable.
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                sreg_s  = {MSB{1'b0}};
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, shift register and bit counter; reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= {MSB{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            sreg_r  <= sreg_s;
            cnt_r   <= cnt_s;
        end
    end

    // Line outputs decode straight from registered state, so they are
    // glitch-free and fall to zero the moment reset is applied.
    assign q_valid = (state_r == SHIFT);
    assign q       = q_valid & sreg_r[MSB-1];
    assign q_last  = q_valid & cnt_zero_s;

    // Ready depends on en so a new word can be taken on the same edge that
    // consumes the last bit of the current one.
    assign din_ready = !rst && ((state_r == IDLE) ||
                                ((state_r == SHIFT) && cnt_zero_s && en));

endmodule : shift_out

// File: tb/tb_shift_out.sv
// Self-checking bench for shift_out with an 8-bit word: table-driven single
// word, hand-written multi-cycle sequences, and randomized traffic against a
// word/bit-count reference model. A bench-side receiver register stands in
// for shift_reg on the loopback path.
module tb_shift_out;
    import shift_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         q;
    logic         q_valid;
    logic         q_last;

    shift_out #(.MSB(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .q         (q),
        .q_valid   (q_valid),
        .q_last    (q_last)
    );

    always #5 clk = ~clk;

    // Reference model: the word being sent and how many of its bits remain
    // on the line (0 means nothing is being sent).
    int           rem = 0;
    logic [W-1:0] mword = '0;
    // Loopback receiver: shifts in q on every enabled edge.
    logic [W-1:0] rx = '0;

    int n_checks = 0;
    int n_fail = 0;
    int step = 0;

    logic obs_q, obs_v, obs_l, obs_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model well
    // before the rising edge, then advance the model across the edge.
    task automatic cycle(input logic v_en, input logic v_valid,
                         input logic [W-1:0] v_din, input logic v_rst);
        logic eq, ev, el, er;
        en        = v_en;
        din_valid = v_valid;
        din       = v_din;
        rst       = v_rst;
        if (v_rst) begin
            rem   = 0;
            mword = '0;
        end
        #2;
        ev = (rem > 0);
        eq = ev ? mword[rem-1] : 1'b0;
        el = (rem == 1);
        er = !v_rst && ((rem == 0) || ((rem == 1) && v_en));
        obs_q = q;
        obs_v = q_valid;
        obs_l = q_last;
        obs_r = din_ready;
        chk("q",         32'(obs_q), 32'(eq));
        chk("q_valid",   32'(obs_v), 32'(ev));
        chk("q_last",    32'(obs_l), 32'(el));
        chk("din_ready", 32'(obs_r), 32'(er));
        @(posedge clk);
        if (v_en) rx = {rx[W-2:0], obs_q};
        if (v_rst) rem = 0;
        else if (er && v_valid) begin
            mword = v_din;
            rem   = W;
        end else if (v_en && rem > 0) rem--;
        step++;
        #1;
    endtask

    typedef struct {
        logic         en;
        logic         valid;
        logic [W-1:0] din;
        logic         q;
        logic         qv;
        logic         ql;
        logic         rdy;
    } vec_t;

    vec_t         tab[10];
    logic [W-1:0] word_ab;
    logic [15:0]  stream, lasts, readys;
    logic [W-1:0] s8;
    int           drops;

    initial begin
        // Reset state.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1);

        // Single word 8'hAB with en held high, table driven.
        word_ab = 8'hAB;
        tab[0] = '{1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 1; i <= 8; i++)
            tab[i] = '{1'b1, 1'b0, 8'h00, word_ab[8-i], 1'b1, (i == 8), (i == 8)};
        tab[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(tab[i].en, tab[i].valid, tab[i].din, 1'b0);
            chk("tab_q",     32'(obs_q), 32'(tab[i].q));
            chk("tab_valid", 32'(obs_v), 32'(tab[i].qv));
            chk("tab_last",  32'(obs_l), 32'(tab[i].ql));
            chk("tab_ready", 32'(obs_r), 32'(tab[i].rdy));
            if (i == 8) chk("loopback_ab", 32'(rx), 32'h000000AB);
        end

        // Back-to-back: 8'h3C presented at the last-bit edge of 8'hAB.
        cycle(1'b1, 1'b1, 8'hAB, 1'b0);
        stream = '0; lasts = '0; drops = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, (k <= 7), (k == 7) ? 8'h3C : 8'hAB, 1'b0);
            stream = {stream[14:0], obs_q};
            lasts  = {lasts[14:0], obs_l};
            if (!obs_v) drops++;
        end
        chk("b2b_stream", 32'(stream), 32'h0000AB3C);
        chk("b2b_last",   32'(lasts),  32'h00000101);
        chk("b2b_drops",  32'(drops),  32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // Duty-cycled enable: every bit held for two cycles.
        cycle(1'b1, 1'b1, 8'hAB, 1'b0);
        stream = '0; readys = '0;
        for (int k = 0; k < 16; k++) begin
            cycle(k[0], 1'b0, 8'h00, 1'b0);
            stream = {stream[14:0], obs_q};
            readys = {readys[14:0], obs_r};
        end
        chk("duty_stream", 32'(stream), 32'h0000CCCF);
        chk("duty_ready",  32'(readys), 32'h00000001);
        chk("duty_loopback", 32'(rx), 32'h000000AB);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-word: outputs clear without waiting for an edge.
        cycle(1'b1, 1'b1, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_async_q",     32'(q),         32'd0);
        chk("rst_async_valid", 32'(q_valid),   32'd0);
        chk("rst_async_last",  32'(q_last),    32'd0);
        chk("rst_async_ready", 32'(din_ready), 32'd0);
        cycle(1'b1, 1'b1, 8'h81, 1'b1);
        cycle(1'b1, 1'b1, 8'h81, 1'b0);
        s8 = '0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            s8 = {s8[W-2:0], obs_q};
        end
        chk("after_rst_word", 32'(s8), 32'h00000081);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // Busy ignore: 8'h55 offered throughout 8'hAB, taken only at the end.
        cycle(1'b1, 1'b1, 8'hAB, 1'b0);
        stream = '0;
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, (k <= 7), 8'h55, 1'b0);
            stream = {stream[14:0], obs_q};
        end
        chk("busy_stream", 32'(stream), 32'h0000AB55);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
                  W'($urandom), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_out
